// File: rtl/gearbox_pkg.sv
// Shared constants for the PCS receive gearbox: default block geometry,
// sync header codes and the supported PMA word-width range.
package gearbox_pkg;
  localparam int GB_HEAD_W  = 2;
  localparam int GB_DATA_W  = 64;
  localparam int GB_BLOCK_W = GB_HEAD_W + GB_DATA_W;
  localparam int PMA_W_MIN  = 16;
  localparam int PMA_W_MAX  = 64;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;
endpackage

// File: rtl/gearbox_rx_insert.sv
// Next-buffer shifter: applies an optional one-bit slip to the surviving bits
// (or to the incoming word when nothing survives), then appends the word above them.
module gearbox_rx_insert #(
  parameter int PMA_W = 64,
  parameter int BUF_W = 129,
  parameter int CNT_W = 8
) (
  input  logic [BUF_W-1:0] buf_i,
  input  logic [CNT_W-1:0] rem_i,
  input  logic             drop_i,
  input  logic [PMA_W-1:0] data_i,
  output logic [BUF_W-1:0] buf_o
);
  logic [BUF_W-1:0] surv;
  logic [BUF_W-1:0] wide;
  logic [BUF_W-1:0] keep;
  logic [CNT_W-1:0] off;

  always_comb begin
    surv = buf_i;
    wide = BUF_W'(data_i);
    off  = rem_i;
    if (drop_i) begin
      if (rem_i != '0) begin
        surv = buf_i >> 1;
        off  = rem_i - CNT_W'(1);
      end else begin
        wide = BUF_W'(data_i) >> 1;
      end
    end
    // Bits above the occupancy are stale and must not leak into the new word.
    keep  = ~({BUF_W{1'b1}} << off);
    buf_o = (surv & keep) | (wide << off);
  end
endmodule

// File: rtl/gearbox_rx_gen.sv
// PCS receive gearbox: PMA_W-bit words in, HEAD_W+DATA_W blocks out, with bit slip
// and flush on lock loss. Define GEARBOX_RX_SLIP_CNT_EN to add the slip_cnt_o counter.
module gearbox_rx_gen
  import gearbox_pkg::*;
#(
  parameter int PMA_W  = 64,
  parameter int HEAD_W = GB_HEAD_W,
  parameter int DATA_W = GB_DATA_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              lock_v_i,
  input  logic [PMA_W-1:0]  data_i,
  input  logic              slip_v_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
`ifdef GEARBOX_RX_SLIP_CNT_EN
  ,
  output logic [15:0]       slip_cnt_o
`endif
);
  localparam int BLOCK_W = HEAD_W + DATA_W;
  localparam int BUF_W   = BLOCK_W + PMA_W - 1;
  localparam int CNT_W   = $clog2(BLOCK_W + PMA_W);

  if (PMA_W < PMA_W_MIN || PMA_W > PMA_W_MAX) begin : g_bad_pma_w
    $error("gearbox_rx_gen: PMA_W out of supported range");
  end

  logic [BUF_W-1:0] buf_q, buf_d, buf_surv;
  logic [CNT_W-1:0] cnt_q, cnt_d, rem;
  logic             blk_v;

  always_comb begin
    blk_v    = (cnt_q >= CNT_W'(BLOCK_W));
    rem      = blk_v ? (cnt_q - CNT_W'(BLOCK_W)) : cnt_q;
    buf_surv = blk_v ? (buf_q >> BLOCK_W) : buf_q;
    cnt_d    = '0;
    if (lock_v_i) begin
      cnt_d = rem - CNT_W'(slip_v_i) + CNT_W'(PMA_W);
    end
  end

  gearbox_rx_insert #(
    .PMA_W(PMA_W),
    .BUF_W(BUF_W),
    .CNT_W(CNT_W)
  ) u_insert (
    .buf_i (buf_surv),
    .rem_i (rem),
    .drop_i(slip_v_i),
    .data_i(data_i),
    .buf_o (buf_d)
  );

  always_ff @(posedge clk) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Buffer contents are meaningless while cnt_q is zero, so they carry no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign valid_o = blk_v;
  assign head_o  = buf_q[HEAD_W-1:0];
  assign data_o  = buf_q[BLOCK_W-1:HEAD_W];

  a_cnt_bound : assert property (@(posedge clk) disable iff (!nreset)
                                 cnt_q <= CNT_W'(BUF_W));

`ifdef GEARBOX_RX_SLIP_CNT_EN
  logic [15:0] slip_cnt_q, slip_cnt_d;

  always_comb begin
    slip_cnt_d = slip_cnt_q;
    if (!lock_v_i)                                slip_cnt_d = '0;
    else if (slip_v_i && slip_cnt_q != 16'hFFFF)  slip_cnt_d = slip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!nreset) slip_cnt_q <= '0;
    else         slip_cnt_q <= slip_cnt_d;
  end

  assign slip_cnt_o = slip_cnt_q;
`endif
endmodule

// File: tb/tb_gearbox_rx_gen.sv
// Self-checking bench for gearbox_rx_gen: a 64-bit PMA instance against a bit-queue
// reference model, and a 32-bit PMA instance against a known block stream.
module tb_gearbox_rx_gen;
  import gearbox_pkg::*;

  localparam int BW = 66;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic        a_lock, a_slip, a_valid;
  logic [63:0] a_data, a_dout;
  logic [1:0]  a_head;
  logic        b_lock, b_slip, b_valid;
  logic [31:0] b_data;
  logic [63:0] b_dout;
  logic [1:0]  b_head;
`ifdef GEARBOX_RX_SLIP_CNT_EN
  logic [15:0] a_scnt, b_scnt;
`endif

  gearbox_rx_gen #(.PMA_W(64), .HEAD_W(2), .DATA_W(64)) u_a (
    .clk(clk), .nreset(nreset), .lock_v_i(a_lock), .data_i(a_data), .slip_v_i(a_slip),
    .valid_o(a_valid), .head_o(a_head), .data_o(a_dout)
`ifdef GEARBOX_RX_SLIP_CNT_EN
    , .slip_cnt_o(a_scnt)
`endif
  );

  gearbox_rx_gen #(.PMA_W(32), .HEAD_W(2), .DATA_W(64)) u_b (
    .clk(clk), .nreset(nreset), .lock_v_i(b_lock), .data_i(b_data), .slip_v_i(b_slip),
    .valid_o(b_valid), .head_o(b_head), .data_o(b_dout)
`ifdef GEARBOX_RX_SLIP_CNT_EN
    , .slip_cnt_o(b_scnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  bit          mq[$];
  logic [65:0] expq[$];
  int          model_slips = 0;

  // One clock of DUT A: model update, scoreboard push, compare, advance.
  task automatic cyc_a(input logic lock, input logic [63:0] d, input logic slip, output logic v);
    logic [65:0] blk;
    bit          drop0;
    a_lock = lock; a_data = d; a_slip = slip;
    if (mq.size() >= BW) begin
      for (int i = 0; i < BW; i++) blk[i] = mq.pop_front();
      expq.push_back(blk);
    end
    if (!lock) begin
      mq.delete();
      model_slips = 0;
    end else begin
      drop0 = 1'b0;
      if (slip) begin
        if (model_slips < 65535) model_slips++;
        if (mq.size() > 0) void'(mq.pop_front());
        else drop0 = 1'b1;
      end
      for (int i = (drop0 ? 1 : 0); i < 64; i++) mq.push_back(d[i]);
    end
    v = a_valid;
    checks++;
    if (a_valid !== (expq.size() > 0)) begin
      failures++;
      $display("FAIL a_valid got=%b exp=%b", a_valid, expq.size() > 0);
    end
    if (expq.size() > 0) begin
      blk = expq.pop_front();
      if (a_valid === 1'b1) begin
        checks++;
        if ({a_dout, a_head} !== blk) begin
          failures++;
          $display("FAIL a_block got=%h exp=%h", {a_dout, a_head}, blk);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic v;
    nreset = 1'b0;
    a_lock = 1'b0; a_slip = 1'b0; a_data = '0;
    b_lock = 1'b0; b_slip = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
    checks++;
    if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
`ifdef GEARBOX_RX_SLIP_CNT_EN
    checks++;
    if (a_scnt !== 16'd0 || b_scnt !== 16'd0) begin
      failures++; $display("FAIL reset_slip_cnt got=%0d/%0d exp=0", a_scnt, b_scnt);
    end
`endif
    nreset = 1'b1;
    for (int k = 0; k < 3; k++) cyc_a(1'b1, {$urandom, $urandom}, 1'b0, v);
    // Reset while locked and full must still clear occupancy.
    nreset = 1'b0;
    @(posedge clk); #1;
    mq.delete(); expq.delete(); model_slips = 0;
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_locked_valid got=%b exp=0", a_valid); end
    nreset = 1'b1;
    cyc_a(1'b0, '0, 1'b0, v);
  endtask

  task automatic test_lock64();
    logic v;
    int   first, nwin;
    first = 0; nwin = 0;
    for (int k = 1; k <= 80; k++) begin
      cyc_a(1'b1, {32'(k) ^ 32'h5A5A_0000, 32'(k)}, 1'b0, v);
      if (v === 1'b1 && first == 0) first = k;
      if (k >= 41 && k <= 73 && v === 1'b1) nwin++;
    end
    checks++;
    if (first != 3) begin failures++; $display("FAIL lock64_first_valid got=%0d exp=3", first); end
    checks++;
    if (nwin != 32) begin failures++; $display("FAIL lock64_cadence got=%0d exp=32", nwin); end
    cyc_a(1'b0, '0, 1'b0, v);
  endtask

  task automatic test_pma32();
    logic [65:0] blks[50];
    logic [65:0] expb[$];
    logic [65:0] eb;
    logic [31:0] word;
    int          bits, np, nwin, j;
    bits = 0; np = 0; nwin = 0;
    for (int k = 0; k < 50; k++)
      blks[k] = {$urandom, $urandom, ((k % 3) == 0) ? SYNC_CTRL : SYNC_DATA};
    for (int c = 0; c < 100; c++) begin
      if (b_valid === 1'b1) begin
        if (c >= 40 && c <= 72) nwin++;
        checks++;
        if (expb.size() == 0) begin
          failures++; $display("FAIL pma32_block got=valid exp=no_block_pending");
        end else begin
          eb = expb.pop_front();
          if ({b_dout, b_head} !== eb) begin
            failures++; $display("FAIL pma32_block got=%h exp=%h", {b_dout, b_head}, eb);
          end
        end
      end
      for (int i = 0; i < 32; i++) begin
        j = c * 32 + i;
        word[i] = blks[j / 66][j % 66];
      end
      b_lock = 1'b1; b_data = word; b_slip = 1'b0;
      bits += 32;
      while (66 * (np + 1) <= bits) begin expb.push_back(blks[np]); np++; end
      @(posedge clk); #1;
    end
    checks++;
    if (nwin != 16) begin failures++; $display("FAIL pma32_cadence got=%0d exp=16", nwin); end
    b_lock = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_slip_rem0();
    logic        v;
    logic [63:0] w0, w1;
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    cyc_a(1'b0, '0, 1'b0, v);
    cyc_a(1'b1, w0, 1'b1, v);
    cyc_a(1'b1, w1, 1'b0, v);
    checks++;
    if (a_valid !== 1'b1 || {a_dout, a_head} !== {w1[2:0], w0[63:1]}) begin
      failures++;
      $display("FAIL slip_rem0_block got=%b/%h exp=1/%h", a_valid, {a_dout, a_head}, {w1[2:0], w0[63:1]});
    end
    for (int k = 0; k < 12; k++) cyc_a(1'b1, {$urandom, $urandom}, 1'b0, v);
  endtask

  task automatic test_slip_on_valid();
    logic v;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) cyc_a(1'b1, {$urandom, $urandom}, 1'b0, v);
      while (mq.size() < BW) cyc_a(1'b1, {$urandom, $urandom}, 1'b0, v);
      cyc_a(1'b1, {$urandom, $urandom}, 1'b1, v);
    end
    for (int k = 0; k < 8; k++) cyc_a(1'b1, {$urandom, $urandom}, 1'b0, v);
  endtask

  task automatic test_slip_66();
    logic [65:0] blks[90];
    logic [63:0] word;
    logic        v;
    int          j;
    for (int k = 0; k < 90; k++) blks[k] = {16'hC0DE, 16'(k), $urandom, SYNC_DATA};
    cyc_a(1'b0, '0, 1'b0, v);
    for (int c = 0; c < 90; c++) begin
      if (c >= 76 && a_valid === 1'b1) begin
        checks++;
        if (a_head !== SYNC_DATA || a_dout[63:48] !== 16'hC0DE) begin
          failures++;
          $display("FAIL slip66_align got=%h/%h exp=%b/c0de", a_head, a_dout[63:48], SYNC_DATA);
        end
      end
      for (int i = 0; i < 64; i++) begin
        j = c * 64 + i;
        word[i] = blks[j / 66][j % 66];
      end
      cyc_a(1'b1, word, (c >= 6 && c < 72), v);
    end
`ifdef GEARBOX_RX_SLIP_CNT_EN
    checks++;
    if (a_scnt !== 16'(model_slips)) begin
      failures++; $display("FAIL slip66_cnt got=%0d exp=%0d", a_scnt, model_slips);
    end
`endif
  endtask

  task automatic test_lock_loss();
    logic v;
    int   first;
    first = 0;
    for (int k = 0; k < 5; k++) cyc_a(1'b1, {$urandom, $urandom}, (k == 1 || k == 3), v);
    cyc_a(1'b0, {$urandom, $urandom}, 1'b1, v);
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL lockloss_valid got=%b exp=0", a_valid); end
`ifdef GEARBOX_RX_SLIP_CNT_EN
    checks++;
    if (a_scnt !== 16'd0) begin failures++; $display("FAIL lockloss_slip_cnt got=%0d exp=0", a_scnt); end
`endif
    for (int k = 1; k <= 6; k++) begin
      cyc_a(1'b1, {$urandom, $urandom}, 1'b0, v);
      if (v === 1'b1 && first == 0) first = k;
    end
    checks++;
    if (first != 3) begin failures++; $display("FAIL relock_first_valid got=%0d exp=3", first); end
    cyc_a(1'b0, '0, 1'b0, v);
  endtask

  initial begin
    test_reset();
    test_lock64();
    test_pma32();
    test_slip_rem0();
    test_slip_on_valid();
    test_slip_66();
    test_lock_loss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
